// File: rtl/bool_exp_pkg.sv
// Shared types and constants for the boolean_exp truth-table sweep controller.
// Field offsets locate f1/f2/f3 inside the packed 24-bit table.
package bool_exp_pkg;

    localparam int unsigned TT_W   = 24;
    localparam int unsigned NVEC   = 8;
    localparam int unsigned F1_LSB = 0;
    localparam int unsigned F2_LSB = 8;
    localparam int unsigned F3_LSB = 16;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StSettle,
        StCapture
    } sweep_state_e;

endpackage

// File: rtl/bool_exp_sweep_ctrl_if.sv
// Start/abort handshake and result bus between a test master and the sweep controller.
// The master modport belongs to the test/config side, slave to the controller.
interface bool_exp_sweep_ctrl_if;
    import bool_exp_pkg::*;

    logic            start;
    logic            abort;
    logic [TT_W-1:0] expect_tt;
    logic            busy;
    logic            done;
    logic [2:0]      vec_idx;
    logic [TT_W-1:0] tt_out;
    logic [NVEC-1:0] mismatch_mask;
    logic            pass;

    modport master (
        output start,
        output abort,
        output expect_tt,
        input  busy,
        input  done,
        input  vec_idx,
        input  tt_out,
        input  mismatch_mask,
        input  pass
    );

    modport slave (
        input  start,
        input  abort,
        input  expect_tt,
        output busy,
        output done,
        output vec_idx,
        output tt_out,
        output mismatch_mask,
        output pass
    );

endinterface

// File: rtl/boolean_exp.sv
// Purely combinational three-input boolean datapath under test.
// Golden truth table: f1 = 8'hCA, f2 = 8'h8B, f3 = 8'h28 (bit i = vector {a,b,c} = i).
module boolean_exp (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic f1,
    output logic f2,
    output logic f3
);

    assign f1 = a ? b : c;
    assign f2 = (b & c) | (~a & ~b);
    assign f3 = c & (a ^ b);

endmodule

// File: rtl/bool_exp_sweep_ctrl.sv
// Sweeps boolean_exp through all eight {a,b,c} vectors, captures f1..f3 into a truth
// table, and compares it against a latched expectation to build a mismatch mask.
module bool_exp_sweep_ctrl
    import bool_exp_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    bool_exp_sweep_ctrl_if.slave bus
);

    // Counter counts down to zero, so SETTLE_CYC wait cycles need a load of SETTLE_CYC-1.
    localparam logic [3:0] SettleLoad = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    sweep_state_e    state_q;
    logic [3:0]      settle_cnt_q;
    logic [2:0]      idx_q;
    logic            a_q, b_q, c_q;
    logic [TT_W-1:0] expect_q;
    logic [NVEC-1:0] tt_f1_q, tt_f2_q, tt_f3_q;
    logic [NVEC-1:0] mask_q;
    logic            done_q;
    logic            pass_q;

    logic            f1, f2, f3;
    logic [NVEC-1:0] exp_f1, exp_f2, exp_f3;
    logic            vec_miss;

    boolean_exp u_datapath (
        .a  (a_q),
        .b  (b_q),
        .c  (c_q),
        .f1 (f1),
        .f2 (f2),
        .f3 (f3)
    );

    assign exp_f1   = expect_q[F1_LSB +: NVEC];
    assign exp_f2   = expect_q[F2_LSB +: NVEC];
    assign exp_f3   = expect_q[F3_LSB +: NVEC];
    assign vec_miss = (f1 != exp_f1[idx_q]) | (f2 != exp_f2[idx_q]) | (f3 != exp_f3[idx_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            settle_cnt_q <= 4'd0;
            idx_q        <= 3'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            c_q          <= 1'b0;
            expect_q     <= '0;
            tt_f1_q      <= '0;
            tt_f2_q      <= '0;
            tt_f3_q      <= '0;
            mask_q       <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.abort) begin
                        expect_q <= bus.expect_tt;
                        tt_f1_q  <= '0;
                        tt_f2_q  <= '0;
                        tt_f3_q  <= '0;
                        mask_q   <= '0;
                        pass_q   <= 1'b0;
                        idx_q    <= 3'd0;
                        state_q  <= StApply;
                    end
                end
                StApply: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                    end else begin
                        {a_q, b_q, c_q} <= idx_q;
                        settle_cnt_q    <= SettleLoad;
                        state_q         <= (SETTLE_CYC == 0) ? StCapture : StSettle;
                    end
                end
                StSettle: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                    end else if (settle_cnt_q == 4'd0) begin
                        state_q <= StCapture;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 4'd1;
                    end
                end
                StCapture: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                    end else begin
                        tt_f1_q[idx_q] <= f1;
                        tt_f2_q[idx_q] <= f2;
                        tt_f3_q[idx_q] <= f3;
                        mask_q[idx_q]  <= vec_miss;
                        if (idx_q == 3'd7) begin
                            // Last vector: fold its own miss in, mask_q not yet updated.
                            pass_q  <= ~(|mask_q) & ~vec_miss;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= StApply;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.tt_out                    = '0;
        bus.tt_out[F1_LSB +: NVEC]    = tt_f1_q;
        bus.tt_out[F2_LSB +: NVEC]    = tt_f2_q;
        bus.tt_out[F3_LSB +: NVEC]    = tt_f3_q;
    end

    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = done_q;
    assign bus.vec_idx       = idx_q;
    assign bus.mismatch_mask = mask_q;
    assign bus.pass          = pass_q;

endmodule
